spram_loader: RTL and testbench

Parametrised SPRAM bootloader and host port. After reset it streams a fixed-size image from the ESP "fread" interface in fixed-size chunks and packs bytes into 16-bit words. It fills one or more SB_SPRAM256KA banks, then hands the banks to user logic through a single flat-address RAM port. It sits between the SPI fread request/response FIFO and the design's RAM consumers.

---
 rtl/spram_loader.sv | 180 ++++++++++++++++++
 tb/tb_spram_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_loader.sv
// rtl/spram_loader.sv - fread-driven SPRAM bootloader with flat-address user RAM port
// Optional checksum port: define SPRAM_LOADER_CHECKSUM_EN.
module spram_loader_bank (
  input  logic        clk,
  input  logic [13:0] address,
  input  logic [15:0] datain,
  input  logic [3:0]  maskwren,
  input  logic        wren,
  input  logic        chipselect,
  input  logic        standby,
  input  logic        sleep,
  input  logic        poweroff,
  output logic [15:0] dataout
);
  logic [15:0] mem [0:16383];
  logic        active;

  assign active = chipselect && poweroff && !standby && !sleep;

  always_ff @(posedge clk) begin
    if (active) begin
      if (wren) begin
        for (int n = 0; n < 4; n++)
          if (maskwren[n]) mem[address][4*n +: 4] <= datain[4*n +: 4];
      end else begin
        dataout <= mem[address];
      end
    end
  end
endmodule

module spram_loader #(
  parameter int          BANKS       = 2,
  parameter int          LOAD_WORDS  = 32768,
  parameter int          CHUNK_BYTES = 2048,
  parameter logic [31:0] BASE_OFFSET = 32'h0,
  localparam int         AW          = 14 + $clog2(BANKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reload,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [31:0]   req_offset,
  input  logic [7:0]    resp_data,
  input  logic          resp_valid,
  output logic          ram_ready,
  input  logic [AW-1:0] address,
  input  logic [15:0]   datain,
  input  logic [3:0]    maskwren,
  input  logic          wren,
  input  logic          chipselect,
  output logic [15:0]   dataout
`ifdef SPRAM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]   checksum
`endif
);
  localparam int BSW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int WCW = $clog2(LOAD_WORDS + 1);
  localparam int BCW = $clog2(CHUNK_BYTES);
  localparam logic [WCW-1:0] LAST_W = WCW'(LOAD_WORDS - 1);
  localparam logic [WCW-1:0] FULL_W = WCW'(LOAD_WORDS);
  localparam logic [BCW-1:0] LAST_B = BCW'(CHUNK_BYTES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_FILL, ST_FLUSH, ST_DONE} state_t;
  state_t state, state_nx;

  logic [BCW-1:0] bcnt;
  logic [WCW-1:0] wcnt;
  logic [7:0]     lo_byte;
  logic           wr_pend;
  logic [AW-1:0]  wr_addr;
  logic [15:0]    wr_data;
  logic           take, chunk_end, img_done, in_user;

  assign take      = (state == ST_FILL) && resp_valid;
  assign chunk_end = take && (bcnt == LAST_B);
  // The last byte of a chunk is always odd, so it completes a word when wcnt is one short.
  assign img_done  = (wcnt >= LAST_W);
  assign in_user   = (state == ST_DONE);
  assign req_valid = (state == ST_REQ);
  assign ram_ready = in_user;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = ST_REQ;
      ST_REQ:   if (req_ready) state_nx = ST_FILL;
      ST_FILL:  if (chunk_end) state_nx = img_done ? ST_FLUSH : ST_REQ;
      ST_FLUSH: state_nx = ST_DONE;
      ST_DONE:  if (reload) state_nx = ST_REQ;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_offset <= BASE_OFFSET;
      bcnt       <= '0;
      wcnt       <= '0;
      lo_byte    <= '0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (take) begin
        bcnt <= bcnt + 1'b1;
        if (!bcnt[0]) begin
          lo_byte <= resp_data;
        end else if (wcnt != FULL_W) begin
          wr_pend <= 1'b1;
          wr_addr <= AW'(wcnt);
          wr_data <= {resp_data, lo_byte};
          wcnt    <= wcnt + 1'b1;
        end
      end
      if (chunk_end && !img_done) req_offset <= req_offset + 32'(CHUNK_BYTES);
      if (in_user && reload) begin
        req_offset <= BASE_OFFSET;
        wcnt       <= '0;
        bcnt       <= '0;
      end
    end
  end

`ifdef SPRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 checksum <= '0;
    else if (in_user && reload) checksum <= '0;
    else if (wr_pend)           checksum <= checksum + wr_data;
  end
`endif

  logic [AW-1:0]  ram_addr;
  logic [BSW-1:0] ram_bank, rd_bank;
  logic [15:0]    bank_dout [BANKS];

  assign ram_addr = in_user ? address : wr_addr;

  if (BANKS > 1) begin : g_sel
    assign ram_bank = ram_addr[AW-1:14];
  end else begin : g_sel1
    assign ram_bank = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_bank <= '0;
    else        rd_bank <= ram_bank;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic cs;
    assign cs = (ram_bank == BSW'(b)) && (in_user ? chipselect : wr_pend);
    spram_loader_bank u_bank (
      .clk        (clk),
      .address    (ram_addr[13:0]),
      .datain     (in_user ? datain : wr_data),
      .maskwren   (in_user ? maskwren : 4'hF),
      .wren       (in_user ? wren : wr_pend),
      .chipselect (cs),
      .standby    (1'b0),
      .sleep      (1'b0),
      .poweroff   (1'b1),
      .dataout    (bank_dout[b])
    );
  end

  always_comb begin
    dataout = '0;
    for (int b = 0; b < BANKS; b++)
      if (rd_bank == BSW'(b)) dataout = bank_dout[b];
  end
endmodule

// File: tb/tb_spram_loader.sv
// tb/tb_spram_loader.sv - self-checking bench for spram_loader against a byte-budget model
module tb_spram_loader;
  localparam int          LOAD  = 16384 + 4;
  localparam int          CHUNK = 8;
  localparam logic [31:0] BASE  = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n, reload, req_valid, req_ready, resp_valid, ram_ready;
  logic [31:0] req_offset;
  logic [7:0]  resp_data;
  logic [14:0] address;
  logic [15:0] datain, dataout;
  logic [3:0]  maskwren;
  logic        wren, chipselect;
`ifdef SPRAM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  spram_loader #(.BANKS(2), .LOAD_WORDS(LOAD), .CHUNK_BYTES(CHUNK), .BASE_OFFSET(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .reload(reload),
    .req_valid(req_valid), .req_ready(req_ready), .req_offset(req_offset),
    .resp_data(resp_data), .resp_valid(resp_valid), .ram_ready(ram_ready),
    .address(address), .datain(datain), .maskwren(maskwren), .wren(wren),
    .chipselect(chipselect), .dataout(dataout)
`ifdef SPRAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, obs_nreq = 0, rr_rises = 0, s = 0, last_cyc = 0, rise_cyc = 0;
  bit prev_rr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sbyte(input int i, input logic [7:0] pat);
    logic [31:0] v;
    v = 32'(i) + (32'(i) >> 8);
    return v[7:0] ^ pat;
  endfunction

  // Model: the loader owes a request, then a CHUNK-byte budget; words fill in stream order.
  bit          m_init = 0, m_want = 0, m_flush = 0, m_ready = 0, m_dout_chk = 0;
  int          m_budget = 0, m_bytes = 0, m_nreq = 0;
  logic [31:0] m_offset = BASE;
  logic [15:0] m_sum = 0, m_dout_exp = 0, m_w;
  logic [7:0]  m_lo = 0;
  logic [15:0] m_mem [0:32767];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_init = 1; m_want = 0; m_budget = 0; m_bytes = 0; m_flush = 0; m_ready = 0;
      m_offset = BASE; m_sum = 0; m_nreq = 0; m_dout_chk = 0;
    end else begin
      m_dout_chk = 0;
      if (m_ready && chipselect) begin
        if (wren) begin
          for (int n = 0; n < 4; n++)
            if (maskwren[n]) m_mem[address][4*n +: 4] = datain[4*n +: 4];
        end else begin
          m_dout_exp = m_mem[address];
          m_dout_chk = 1;
        end
      end
      if (m_init) begin
        m_init = 0; m_want = 1;
      end else if (m_want) begin
        if (req_ready) begin m_want = 0; m_budget = CHUNK; m_nreq++; end
      end else if (m_budget > 0) begin
        if (resp_valid) begin
          if (m_bytes < 2 * LOAD) begin
            if (m_bytes % 2 == 0) m_lo = resp_data;
            else begin
              m_w = {resp_data, m_lo};
              m_mem[15'(m_bytes / 2)] = m_w;
              m_sum = m_sum + m_w;
            end
            m_bytes++;
          end
          m_budget--;
          if (m_budget == 0) begin
            if (m_bytes >= 2 * LOAD) m_flush = 1;
            else begin m_want = 1; m_offset = m_offset + 32'(CHUNK); end
          end
        end
      end else if (m_flush) begin
        m_flush = 0; m_ready = 1;
      end else if (m_ready && reload) begin
        m_ready = 0; m_want = 1; m_offset = BASE; m_bytes = 0; m_sum = 0; m_nreq = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && req_valid && req_ready) obs_nreq++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("req_valid", 32'(req_valid), 32'(m_want));
      if (m_want) check("req_offset", req_offset, m_offset);
      check("ram_ready", 32'(ram_ready), 32'(m_ready));
      if (m_dout_chk) check("dataout", 32'(dataout), 32'(m_dout_exp));
`ifdef SPRAM_LOADER_CHECKSUM_EN
      if (m_ready) check("checksum", 32'(checksum), 32'(m_sum));
`endif
      if (ram_ready && !prev_rr) rr_rises++;
    end
    prev_rr = ram_ready;
  end

  task automatic run_load(input int max_cyc, input int stop_reqs, input logic [7:0] pat,
                          input bit stress, output bit done);
    int base = obs_nreq;
    int dly = 0;
    done = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      reload = 0;
      if (ram_ready) begin done = 1; rise_cyc = cyc; break; end
      if (stop_reqs > 0 && obs_nreq - base >= stop_reqs) begin done = 1; break; end
      resp_valid = 0;
      req_ready  = 0;
      if (m_want) begin
        if (stress && m_nreq == 1 && dly < 5) begin
          dly++;
          resp_valid = dly[0];
          resp_data  = 8'hA5;
          check("held_valid", 32'(req_valid), 32'd1);
          check("held_offset", req_offset, 32'h108);
        end else begin
          req_ready = 1;
        end
      end else if (m_budget > 0) begin
        resp_valid = 1;
        resp_data  = sbyte(s, pat);
        if (s == 2 * LOAD - 1) last_cyc = cyc;
        s++;
      end else if (m_flush) begin
        resp_valid = 1;
        resp_data  = 8'h5A;
      end
      if (stress && (c % 97) == 50) reload = 1;
    end
  endtask

  task automatic user_rd(input logic [14:0] a, input logic [15:0] exp, input string nm);
    address = a; chipselect = 1; wren = 0;
    @(posedge clk); #1;
    chipselect = 0;
    check(nm, 32'(dataout), 32'(exp));
  endtask

  task automatic user_wr(input logic [14:0] a, input logic [15:0] d, input logic [3:0] m);
    address = a; datain = d; maskwren = m; wren = 1; chipselect = 1;
    @(posedge clk); #1;
    chipselect = 0; wren = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit done;
    int base, rbase;
    rst_n = 0; reload = 0; req_ready = 0; resp_valid = 0; resp_data = 0;
    address = 0; datain = 0; maskwren = 0; wren = 0; chipselect = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_ram_ready", 32'(ram_ready), 32'd0);
    check("rst_req_offset", req_offset, 32'h100);
`ifdef SPRAM_LOADER_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif
    rst_n = 1;
    run_load(14, 0, 8'h00, 0, done);

    rst_n = 0;
    @(posedge clk); #1;
    resp_valid = 0; req_ready = 0;
    check("midrst_req_valid", 32'(req_valid), 32'd0);
    check("midrst_req_offset", req_offset, 32'h100);
    rst_n = 1; s = 0;
    @(posedge clk); #1;
    check("first_req_valid", 32'(req_valid), 32'd1);
    check("first_offset", req_offset, 32'h100);

    base = obs_nreq; rbase = rr_rises;
    run_load(45000, 0, 8'h00, 1, done);
    check("load_done", 32'(done), 32'd1);
    check("req_count", 32'(obs_nreq - base), 32'd4097);
    check("ready_latency", 32'(rise_cyc - last_cyc), 32'd2);

    resp_valid = 1; resp_data = 8'h5A;
    user_rd(15'd0,     16'h0100, "rd_addr0");
    user_rd(15'd1,     16'h0302, "rd_addr1");
    user_rd(15'd16384, 16'h8180, "rd_bank1_addr0");
    user_rd(15'd16385, 16'h8382, "rd_addr16385");
    user_rd(15'd16387, 16'h8786, "rd_last_word");
    resp_valid = 0;
    user_wr(15'd16385, 16'hBEEF, 4'h3);
    user_rd(15'd16385, 16'h83EF, "rd_masked_write");
    user_rd(15'd0,     16'h0100, "rd_addr0_after_write");
    repeat (4) @(posedge clk);
    #1;
    check("ready_rises", 32'(rr_rises - rbase), 32'd1);

    reload = 1;
    @(posedge clk); #1;
    reload = 0;
    check("reload_req_valid", 32'(req_valid), 32'd1);
    check("reload_offset", req_offset, 32'h100);
    check("reload_ram_ready", 32'(ram_ready), 32'd0);
    s = 0; base = obs_nreq;
`ifdef SPRAM_LOADER_CHECKSUM_EN
    run_load(45000, 0, 8'h3C, 0, done);
    check("reload_done", 32'(done), 32'd1);
    check("reload_req_count", 32'(obs_nreq - base), 32'd4097);
    user_rd(15'd0, 16'h3D3C, "rd2_addr0");
`else
    run_load(40, 3, 8'h3C, 0, done);
    check("reload_reqs", 32'(obs_nreq - base), 32'd3);
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
